// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and width helpers for the multi-port register file
package regfile_pkg;

   localparam int DEFAULT_DATA_W   = 16;
   localparam int DEFAULT_NUM_REGS = 8;

   function automatic int selWidth(input int numRegs);
      return (numRegs > 1) ? $clog2(numRegs) : 1;
   endfunction

   function automatic int beWidth(input int dataW);
      return dataW / 8;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with lock-over-clear priority
// Macro-independent; BYPASS selects whether the read view shows post-update busy bits.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int SEL_W    = selWidth(NUM_REGS),
   parameter int ZERO_R0  = 0,
   parameter bit BYPASS   = 1'b0
) (
   input  logic                I_clk,
   input  logic                I_reset,
   input  logic                enable,
   input  logic                lock,
   input  logic [SEL_W-1:0]    lockSelect,
   input  logic                clear,
   input  logic [SEL_W-1:0]    clearSelect,
   output logic [NUM_REGS-1:0] busyView
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busyNext;

   // Lock is applied after clear so a new producer wins over a retiring write.
   always_comb begin
      busyNext = busy;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ZERO_R0 == 0 || i != 0) begin
            if (enable && clear && clearSelect == SEL_W'(i)) busyNext[i] = 1'b0;
            if (enable && lock && lockSelect == SEL_W'(i))   busyNext[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         busy <= '0;
      end else begin
         busy <= busyNext;
      end
   end

   assign busyView = BYPASS ? busyNext : busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read one-write register file with byte enables and busy scoreboard
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding of data and busy.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int  DATA_W   = DEFAULT_DATA_W,
   parameter int  NUM_REGS = DEFAULT_NUM_REGS,
   parameter int  ZERO_R0  = 0,
   localparam int SEL_W    = selWidth(NUM_REGS),
   localparam int BE_W     = beWidth(DATA_W)
) (
   input  logic              I_clk,
   input  logic              I_reset,
   input  logic              I_enable,
   input  logic [SEL_W-1:0]  I_rA_select,
   input  logic [SEL_W-1:0]  I_rB_select,
   input  logic [SEL_W-1:0]  I_rD_select,
   input  logic [DATA_W-1:0] I_rD_in,
   input  logic              I_rD_write,
   input  logic [BE_W-1:0]   I_rD_be,
   input  logic              I_lock,
   input  logic [SEL_W-1:0]  I_lock_select,
   output logic [DATA_W-1:0] O_rA_out,
   output logic [DATA_W-1:0] O_rB_out,
   output logic              O_rA_busy,
   output logic              O_rB_busy
);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_REGS-1:0][DATA_W-1:0] regsNext;
   logic [NUM_REGS-1:0][DATA_W-1:0] readArr;
   logic [NUM_REGS-1:0]             busyView;
   logic [DATA_W-1:0]               rAData;
   logic [DATA_W-1:0]               rBData;
   logic                            rABusy;
   logic                            rBBusy;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W),
      .ZERO_R0  (ZERO_R0),
      .BYPASS   (BYPASS)
   ) scoreboard (
      .I_clk       (I_clk),
      .I_reset     (I_reset),
      .enable      (I_enable),
      .lock        (I_lock),
      .lockSelect  (I_lock_select),
      .clear       (I_rD_write & (|I_rD_be)),
      .clearSelect (I_rD_select),
      .busyView    (busyView)
   );

   // Out-of-range selects never match a loop index, so they neither write nor read.
   always_comb begin
      regsNext = regs;
      for (int i = 0; i < NUM_REGS; i++) begin
         if ((ZERO_R0 == 0 || i != 0) && I_enable && I_rD_write && I_rD_select == SEL_W'(i)) begin
            for (int k = 0; k < BE_W; k++) begin
               if (I_rD_be[k]) regsNext[i][8*k +: 8] = I_rD_in[8*k +: 8];
            end
         end
      end
   end

   assign readArr = BYPASS ? regsNext : regs;

   always_comb begin
      rAData = '0;
      rBData = '0;
      rABusy = 1'b0;
      rBBusy = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (I_rA_select == SEL_W'(i)) begin
            rAData = readArr[i];
            rABusy = busyView[i];
         end
         if (I_rB_select == SEL_W'(i)) begin
            rBData = readArr[i];
            rBBusy = busyView[i];
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         regs <= '0;
      end else begin
         regs <= regsNext;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         O_rA_out  <= '0;
         O_rB_out  <= '0;
         O_rA_busy <= 1'b0;
         O_rB_busy <= 1'b0;
      end else if (I_enable) begin
         O_rA_out  <= rAData;
         O_rB_out  <= rBData;
         O_rA_busy <= rABusy;
         O_rB_busy <= rBBusy;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and random checks of regfile_mp against a behavioural model
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset, enable, rdWrite, lock;
   logic [2:0]  aSel, bSel, dSel, lSel;
   logic [15:0] din;
   logic [1:0]  be;
   logic [15:0] aOut0, bOut0, aOut1, bOut1;
   logic        aBusy0, bBusy0, aBusy1, bBusy1;

   int errors = 0;
   int checks = 0;

   logic [15:0] mReg  [2][8];
   bit          mBusy [2][8];
   logic [15:0] mA [2];
   logic [15:0] mB [2];
   bit          mAB [2];
   bit          mBB [2];

   always #5 clk = ~clk;

   regfile_mp dut0 (
      .I_clk(clk), .I_reset(reset), .I_enable(enable),
      .I_rA_select(aSel), .I_rB_select(bSel), .I_rD_select(dSel),
      .I_rD_in(din), .I_rD_write(rdWrite), .I_rD_be(be),
      .I_lock(lock), .I_lock_select(lSel),
      .O_rA_out(aOut0), .O_rB_out(bOut0), .O_rA_busy(aBusy0), .O_rB_busy(bBusy0)
   );

   regfile_mp #(.DATA_W(16), .NUM_REGS(6), .ZERO_R0(1)) dut1 (
      .I_clk(clk), .I_reset(reset), .I_enable(enable),
      .I_rA_select(aSel), .I_rB_select(bSel), .I_rD_select(dSel),
      .I_rD_in(din), .I_rD_write(rdWrite), .I_rD_be(be),
      .I_lock(lock), .I_lock_select(lSel),
      .O_rA_out(aOut1), .O_rB_out(bOut1), .O_rA_busy(aBusy1), .O_rB_busy(bBusy1)
   );

   // Instance 0: 8 regs, r0 writable. Instance 1: 6 regs, r0 hardwired zero.
   function automatic bit writable(input int d, input logic [2:0] sel);
      int n = (d == 0) ? 8 : 6;
      return (int'(sel) < n) && !(d == 1 && sel == 3'd0);
   endfunction

   task automatic model(input int d);
      logic [15:0] nr [8];
      bit          nb [8];
      logic [15:0] mask;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            mReg[d][i]  = 16'h0;
            mBusy[d][i] = 1'b0;
         end
         mA[d] = 16'h0; mB[d] = 16'h0; mAB[d] = 1'b0; mBB[d] = 1'b0;
         return;
      end
      if (!enable) return;
      for (int i = 0; i < 8; i++) begin
         nr[i] = mReg[d][i];
         nb[i] = mBusy[d][i];
      end
      mask = {{8{be[1]}}, {8{be[0]}}};
      if (rdWrite && writable(d, dSel)) begin
         nr[dSel] = (nr[dSel] & ~mask) | (din & mask);
         if (be != 2'b00) nb[dSel] = 1'b0;
      end
      if (lock && writable(d, lSel)) nb[lSel] = 1'b1;
`ifdef REGFILE_BYPASS_EN
      mA[d]  = writable(d, aSel) ? nr[aSel] : 16'h0;
      mB[d]  = writable(d, bSel) ? nr[bSel] : 16'h0;
      mAB[d] = writable(d, aSel) ? nb[aSel] : 1'b0;
      mBB[d] = writable(d, bSel) ? nb[bSel] : 1'b0;
`else
      mA[d]  = writable(d, aSel) ? mReg[d][aSel]  : 16'h0;
      mB[d]  = writable(d, bSel) ? mReg[d][bSel]  : 16'h0;
      mAB[d] = writable(d, aSel) ? mBusy[d][aSel] : 1'b0;
      mBB[d] = writable(d, bSel) ? mBusy[d][bSel] : 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         mReg[d][i]  = nr[i];
         mBusy[d][i] = nb[i];
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model(0);
      model(1);
      #1;
      check("d0_rA_out",  aOut0, mA[0]);
      check("d0_rB_out",  bOut0, mB[0]);
      check("d0_rA_busy", {15'h0, aBusy0}, {15'h0, mAB[0]});
      check("d0_rB_busy", {15'h0, bBusy0}, {15'h0, mBB[0]});
      check("d1_rA_out",  aOut1, mA[1]);
      check("d1_rB_out",  bOut1, mB[1]);
      check("d1_rA_busy", {15'h0, aBusy1}, {15'h0, mAB[1]});
      check("d1_rB_busy", {15'h0, bBusy1}, {15'h0, mBB[1]});
   endtask

   task automatic drive(input logic r, input logic e, input logic w, input logic [2:0] ds,
                        input logic [15:0] d, input logic [1:0] b, input logic l,
                        input logic [2:0] ls, input logic [2:0] as, input logic [2:0] bs);
      reset = r; enable = e; rdWrite = w; dSel = ds; din = d; be = b;
      lock = l; lSel = ls; aSel = as; bSel = bs;
   endtask

   task automatic readOnly(input logic [2:0] as, input logic [2:0] bs);
      drive(0, 1, 0, 0, 16'h0, 2'b00, 0, 0, as, bs);
      step();
   endtask

   initial begin
      drive(1, 1, 1, 3, 16'hDEAD, 2'b11, 1, 3, 3, 3);
      step();
      check("reset_rA_out", aOut0, 16'h0);
      drive(1, 0, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0);
      step();

      drive(0, 1, 1, 3, 16'hBEEF, 2'b11, 0, 0, 0, 1);
      step();
      readOnly(3, 0);
      check("r3_beef", aOut0, 16'hBEEF);

      drive(0, 1, 1, 5, 16'h1234, 2'b11, 0, 0, 0, 0);
      step();
      drive(0, 1, 1, 5, 16'hABCD, 2'b01, 0, 0, 0, 0);
      step();
      readOnly(5, 5);
      check("r5_be01", aOut0, 16'h12CD);
      drive(0, 1, 1, 5, 16'hABCD, 2'b10, 0, 0, 0, 0);
      step();
      readOnly(5, 5);
      check("r5_be10", bOut0, 16'hABCD);
      drive(0, 1, 1, 5, 16'h5555, 2'b00, 0, 0, 0, 0);
      step();
      readOnly(5, 5);
      check("r5_be00", aOut0, 16'hABCD);

      drive(0, 1, 0, 0, 16'h0, 2'b00, 1, 2, 0, 0);
      step();
      readOnly(2, 2);
      check("r2_locked", {15'h0, aBusy0}, 16'h1);
      drive(0, 1, 1, 2, 16'h7777, 2'b11, 1, 2, 0, 0);
      step();
      readOnly(2, 2);
      check("r2_lock_write", {15'h0, aBusy0}, 16'h1);
      drive(0, 1, 1, 2, 16'h8888, 2'b11, 0, 0, 0, 0);
      step();
      readOnly(2, 2);
      check("r2_write_only", {15'h0, aBusy0}, 16'h0);

      drive(0, 1, 1, 4, 16'h1111, 2'b11, 0, 0, 0, 0);
      step();
      drive(0, 1, 1, 4, 16'h00FF, 2'b11, 1, 4, 4, 4);
      step();
`ifdef REGFILE_BYPASS_EN
      check("r4_fwd", aOut0, 16'h00FF);
`else
      check("r4_fwd", aOut0, 16'h1111);
`endif

      drive(0, 1, 1, 0, 16'hFFFF, 2'b11, 1, 0, 0, 0);
      step();
      readOnly(0, 0);
      check("z_r0_data", aOut1, 16'h0);
      check("z_r0_busy", {15'h0, aBusy1}, 16'h0);
      drive(0, 0, 1, 1, 16'hCAFE, 2'b11, 1, 1, 1, 1);
      step();
      check("hold_rA", aOut0, 16'h0000 | mA[0]);
      readOnly(1, 7);
      check("hold_r1", aOut1, 16'h0);

      drive(0, 1, 1, 7, 16'h4321, 2'b11, 1, 7, 7, 6);
      step();
      readOnly(7, 6);
      check("oor_d1", aOut1, 16'h0);

      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
               3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         step();
      end

      drive(0, 1, 1, 6, 16'h9999, 2'b11, 1, 6, 6, 6);
      step();
      drive(1, 1, 1, 6, 16'hAAAA, 2'b11, 1, 6, 6, 6);
      step();
      check("mid_reset_rA", aOut0, 16'h0);
      check("mid_reset_busy", {15'h0, aBusy0}, 16'h0);
      readOnly(6, 3);
      check("post_reset_r6", aOut0, 16'h0);
      check("post_reset_b6", {15'h0, aBusy0}, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
